// File: rtl/ex_div_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : ex_div_pkg                                                    |
// | Purpose: Shared constants for the EX-stage divider: state codes,       |
// |          ready/start levels, datapath widths and the state type.       |
// | Ports  : none (package)                                                |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
package ex_div_pkg;

   localparam int DIV_DATA_W     = 32;
   localparam int DOUBLE_REG_BUS = 2 * DIV_DATA_W;

   // State codes
   localparam logic [1:0] DIV_FREE_C   = 2'b00;
   localparam logic [1:0] DIV_BYZERO_C = 2'b01;
   localparam logic [1:0] DIV_ON_C     = 2'b10;
   localparam logic [1:0] DIV_END_C    = 2'b11;

   // Handshake levels
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;

   typedef enum logic [1:0] {
      ST_FREE   = DIV_FREE_C,
      ST_BYZERO = DIV_BYZERO_C,
      ST_ON     = DIV_ON_C,
      ST_END    = DIV_END_C
   } div_state_e;

endpackage : ex_div_pkg
`default_nettype wire

// File: rtl/ex_div.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : ex_div                                                        |
// | Purpose: Iterative radix-2 restoring divider (DIV / DIVU) beside EX.   |
// |          One quotient bit per clock; result = {remainder, quotient}.   |
// | Ports  : clk, rst         clock, synchronous active-high reset         |
// |          signed_div_i     1 = DIV, 0 = DIVU (sampled with start)       |
// |          opdata1_i/2_i    dividend / divisor (sampled on start edge)   |
// |          start_i          held high by EX until ready_o is seen        |
// |          annul_i          abort (flush / cancel)                       |
// |          result_o         {rem, quot}, valid while ready_o = 1         |
// |          ready_o          registered result-valid flag                 |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module ex_div
   import ex_div_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   input  logic                start_i,
   input  logic                annul_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o
);

   localparam int                CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   div_state_e                state_q,  state_d;
   logic [CNT_W-1:0]          cnt_q,    cnt_d;
   // Partial remainder is always below the divisor, so its extra top bit
   // is constant zero between steps and is not stored.
   logic [DATA_W-1:0]         rem_q,    rem_d;
   logic [DATA_W-1:0]         quo_q,    quo_d;    // dividend shifting out, quotient shifting in
   logic [DATA_W-1:0]         dvsr_q,   dvsr_d;
   logic                      neg1_q,   neg1_d;
   logic                      neg2_q,   neg2_d;
   logic                      sgn_q,    sgn_d;
   logic                      ready_q,  ready_d;
   logic [2*DATA_W-1:0]       result_q, result_d;

   // One restoring step: returns {next remainder, next quotient/dividend}.
   function automatic logic [2*DATA_W-1:0] div_step(
      input logic [DATA_W-1:0] r,
      input logic [DATA_W-1:0] q,
      input logic [DATA_W-1:0] d
   );
      logic [DATA_W:0]   diff;
      logic [DATA_W-1:0] r_n;
      logic [DATA_W-1:0] q_n;
      diff = {r, q[DATA_W-1]} - {1'b0, d};
      // A borrow leaves the top bit set: trial subtraction failed, restore.
      if (diff[DATA_W]) begin
         r_n = {r[DATA_W-2:0], q[DATA_W-1]};
         q_n = {q[DATA_W-2:0], 1'b0};
      end else begin
         r_n = diff[DATA_W-1:0];
         q_n = {q[DATA_W-2:0], 1'b1};
      end
      return {r_n, q_n};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_FREE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
         neg1_q   <= 1'b0;
         neg2_q   <= 1'b0;
         sgn_q    <= 1'b0;
         ready_q  <= DIV_RESULT_NOT_READY;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvsr_q   <= dvsr_d;
         neg1_q   <= neg1_d;
         neg2_q   <= neg2_d;
         sgn_q    <= sgn_d;
         ready_q  <= ready_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      logic [2*DATA_W-1:0] step;
      logic [DATA_W-1:0]   quot_fix;
      logic [DATA_W-1:0]   rem_fix;

      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvsr_d   = dvsr_q;
      neg1_d   = neg1_q;
      neg2_d   = neg2_q;
      sgn_d    = sgn_q;
      ready_d  = ready_q;
      result_d = result_q;
      step     = div_step(rem_q, quo_q, dvsr_q);
      quot_fix = (sgn_q && (neg1_q ^ neg2_q)) ? -quo_q : quo_q;
      rem_fix  = (sgn_q && neg1_q) ? -rem_q : rem_q;

      unique case (state_q)
         ST_FREE: begin
            ready_d  = DIV_RESULT_NOT_READY;
            result_d = '0;
            // annul wins over a simultaneous start
            if (start_i == DIV_START && !annul_i) begin
               cnt_d = '0;
               if (opdata2_i == '0) begin
                  state_d = ST_BYZERO;
               end else begin
                  state_d = ST_ON;
                  sgn_d   = signed_div_i;
                  neg1_d  = signed_div_i & opdata1_i[DATA_W-1];
                  neg2_d  = signed_div_i & opdata2_i[DATA_W-1];
                  // |0x8000_0000| stays 0x8000_0000 as an unsigned magnitude
                  quo_d   = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
                  dvsr_d  = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
                  rem_d   = '0;
               end
            end
         end

         ST_BYZERO: begin
            // Two-edge divide-by-zero latency: cnt marks the spare cycle.
            if (cnt_q == '0) begin
               cnt_d = CNT_ONE;
            end else begin
               cnt_d    = '0;
               state_d  = ST_END;
               result_d = '0;
               ready_d  = DIV_RESULT_READY;
            end
         end

         ST_ON: begin
            if (annul_i || start_i == DIV_STOP) begin
               state_d  = ST_FREE;
               ready_d  = DIV_RESULT_NOT_READY;
               result_d = '0;
               cnt_d    = '0;
            end else if (cnt_q != CNT_LAST) begin
               rem_d = step[2*DATA_W-1:DATA_W];
               quo_d = step[DATA_W-1:0];
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               result_d = {rem_fix, quot_fix};
               ready_d  = DIV_RESULT_READY;
               state_d  = ST_END;
               cnt_d    = '0;
            end
         end

         ST_END: begin
            // annul_i is deliberately ignored: the result is already final.
            if (start_i == DIV_STOP) begin
               state_d  = ST_FREE;
               ready_d  = DIV_RESULT_NOT_READY;
               result_d = '0;
            end
         end

         default: state_d = ST_FREE;
      endcase
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule : ex_div
`default_nettype wire

// File: tb/tb_ex_div.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_ex_div                                                     |
// | Purpose: Scoreboard bench for ex_div: directed corner cases plus       |
// |          random DIV/DIVU against an arithmetic reference model.        |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_ex_div;
   import ex_div_pkg::*;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           signed_div;
   logic [W-1:0]   op1, op2;
   logic           start, annul;
   logic [2*W-1:0] result;
   logic           ready;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [2*W-1:0] res;
      int             rdy_cyc;
   } exp_t;
   exp_t sb[$];

   ex_div #(.DATA_W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (op1),
      .opdata2_i    (op2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: plain magnitude arithmetic with sign rules applied after.
   function automatic logic [2*W-1:0] ref_div(input logic s, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      logic [W-1:0] ma, mb, mq, mr, q, r;
      if (b == 0) return '0;
      ma = (s && a[W-1]) ? (~a + 1) : a;
      mb = (s && b[W-1]) ? (~b + 1) : b;
      mq = ma / mb;
      mr = ma % mb;
      q  = (s && (a[W-1] != b[W-1])) ? (~mq + 1) : mq;
      r  = (s && a[W-1]) ? (~mr + 1) : mr;
      return {r, q};
   endfunction

   task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: pops one expectation on each rising ready_o.
   logic ready_prev = 1'b0;
   always @(posedge clk) begin
      #1;
      if (ready && !ready_prev) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ready: ready_o rose at cycle %0d with nothing pending", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", result, e.res);
            check("latency", 64'(cyc), 64'(e.rdy_cyc));
            check("no_x", 64'($isunknown(result)), 64'd0);
         end
      end
      ready_prev = ready;
   end

   // Issue one division, hold start until ready plus `hold` extra cycles, then release.
   task automatic do_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] expv, input int lat, input int hold);
      exp_t e;
      bit   seen;
      @(negedge clk);
      signed_div = s; op1 = a; op2 = b; start = 1'b1;
      @(posedge clk); #1;
      e.res = expv; e.rdy_cyc = cyc + lat;
      sb.push_back(e);
      // Operands wander after the start edge; the divider must ignore them.
      @(negedge clk);
      op1 = $urandom; op2 = $urandom; signed_div = $urandom_range(0, 1);
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (ready) begin seen = 1; break; end
      end
      if (!seen) begin
         checks++; failures++;
         $display("FAIL ready_timeout: ready_o=0 required 1 within 60 cycles");
         void'(sb.pop_front());
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("end_hold", {result[2*W-2:0], ready}, {expv[2*W-2:0], 1'b1});
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      check("release", {ready, result}, '0);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'd1;
         4:       return W'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [W-1:0] a, b;
      logic         s;
      rst = 1'b1; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {ready, result}, '0);
      check("reset_state", 64'(dut.state_q), 64'(ST_FREE));
      @(negedge clk); rst = 1'b0;

      // Directed cases
      do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 5);
      do_div(1'b1, -32'sd7, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
      do_div(1'b1, 32'd7, -32'sd2, {32'd1, 32'hFFFF_FFFD}, 33, 0);
      do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 1);
      do_div(1'b0, 32'd55, 32'd0, '0, 2, 2);

      // start and annul together in FREE: annul wins
      @(negedge clk);
      op1 = 32'd10; op2 = 32'd3; start = 1'b1; annul = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("annul_wins_free", 64'(dut.state_q), 64'(ST_FREE));
      end
      @(negedge clk); start = 1'b0; annul = 1'b0;

      // Abort at iteration 10, start still high through the annul edge
      @(negedge clk);
      signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      repeat (10) @(posedge clk);
      @(negedge clk); annul = 1'b1;
      @(posedge clk); #1;
      check("annul_to_free", {62'(dut.state_q), ready, |result}, {62'(ST_FREE), 2'b00});
      @(negedge clk); annul = 1'b0; start = 1'b0;
      begin
         bit rose = 0;
         for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready) rose = 1;
         end
         check("annul_no_ready", 64'(rose), 64'd0);
      end
      do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0);

      // Reset at iteration 20
      @(negedge clk);
      signed_div = 1'b0; op1 = 32'd50000; op2 = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      repeat (19) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("reset_mid_outputs", {ready, result}, '0);
      check("reset_mid_state", 64'(dut.state_q), 64'(ST_FREE));
      @(negedge clk); rst = 1'b0; start = 1'b0;
      repeat (5) @(posedge clk);

      // Random DIV/DIVU
      for (int n = 0; n < 40; n++) begin
         s = $urandom_range(0, 1);
         a = pick();
         b = pick();
         do_div(s, a, b, ref_div(s, a, b), (b == 0) ? 2 : 33, $urandom_range(0, 3));
      end

      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_ex_div
`default_nettype wire
